// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state and the machine word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/memory_arbiter.sv
// Serialises icache fills and dcache accesses onto one RAM port; data wins unless
// instruction fetch has been starved for MAX_DSTREAK consecutive data grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    r_state;
  logic [SW-1:0] r_streak;
  logic          r_err;

  logic w_dreq, w_access, w_i_done, w_d_done, w_force_i;

  assign w_dreq    = dREN | dWEN;
  assign w_access  = (ramstate == ACCESS);
  assign w_i_done  = (r_state == GNT_I) && iREN && w_access;
  assign w_d_done  = (r_state == GNT_D) && w_dreq && w_access;
  assign w_force_i = iREN && (r_streak == STREAK_MAX);

  // A dropped request releases the grant without an ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !w_force_i) r_state <= GNT_D;
          else if (iREN)            r_state <= GNT_I;
        end
        GNT_I:   if (!iREN || w_access)   r_state <= IDLE;
        GNT_D:   if (!w_dreq || w_access) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_streak <= '0;
    end else if (w_d_done) begin
      if (!iREN)                        r_streak <= '0;
      else if (r_streak != STREAK_MAX)  r_streak <= r_streak + 1'b1;
    end else if (w_i_done) begin
      r_streak <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if ((dREN && dWEN) || ((r_state != IDLE) && (ramstate == ERROR))) begin
      r_err <= 1'b1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !w_i_done;
      end
      GNT_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !w_d_done;
      end
      default: ;
    endcase
    iload = ramload;
    dload = ramload;
    err   = r_err;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a port-ownership model and a scripted RAM responder.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  ramstate_t   ramstate = FREE;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  assign ramload = (ramaddr == 32'h40) ? 32'h8C010004 : {ramaddr[15:0], 16'hA5A5};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM responder: ERROR for err_n strobe cycles, then ACCESS after lat more.
  int lat = 2, err_n = 0, cnt = 0;
  always @(posedge CLK) begin
    #2;
    if (ramREN === 1'b1 || ramWEN === 1'b1) cnt++;
    else cnt = 0;
    if (cnt == 0)                 ramstate = FREE;
    else if (cnt <= err_n)        ramstate = ERROR;
    else if (cnt >= err_n + lat)  ramstate = ACCESS;
    else                          ramstate = BUSY;
  end

  // Model: who owns the RAM port (0 nobody, 1 icache, 2 dcache), streak, sticky error.
  int m_own = 0, m_streak = 0;
  bit m_err = 0, m_valid = 0;
  always @(posedge CLK) begin
    bit dreq, acc;
    dreq = dREN || dWEN;
    acc  = (ramstate == ACCESS);
    if (RST) begin
      m_own = 0; m_streak = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      if ((dREN && dWEN) || (m_own != 0 && ramstate == ERROR)) m_err = 1;
      if (m_own == 0) begin
        if (dreq && !(iREN && m_streak == 4)) m_own = 2;
        else if (iREN)                       m_own = 1;
      end else if (m_own == 1) begin
        if (iREN && acc) m_streak = 0;
        if (!iREN || acc) m_own = 0;
      end else begin
        if (dreq && acc) m_streak = iREN ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
        if (!dreq || acc) m_own = 0;
      end
    end
  end

  int ack_q[$];
  logic [31:0] last_iload, last_daddr, last_dstore;
  logic        last_dwen;

  always @(negedge CLK) begin
    logic        e_ren, e_wen, e_iw, e_dw, chk_store;
    logic [31:0] e_addr, e_store;
    if (m_valid) begin
      e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = 0; e_store = 0; chk_store = 1;
      if (m_own == 1) begin
        e_ren = iREN; e_addr = iaddr; chk_store = 0;
        e_iw = !(iREN && ramstate == ACCESS);
      end else if (m_own == 2) begin
        e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
        e_dw = !((dREN || dWEN) && ramstate == ACCESS);
      end
      chk("ramREN", 32'(ramREN), 32'(e_ren));
      chk("ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("ramaddr", ramaddr, e_addr);
      if (chk_store) chk("ramstore", ramstore, e_store);
      chk("iwait", 32'(iwait), 32'(e_iw));
      chk("dwait", 32'(dwait), 32'(e_dw));
      chk("err", 32'(err), 32'(m_err));
      chk("iload", iload, ramload);
      chk("dload", dload, ramload);
      if (iwait === 1'b0) begin ack_q.push_back(1); last_iload = iload; end
      if (dwait === 1'b0) begin
        ack_q.push_back(2);
        last_daddr = ramaddr; last_dstore = ramstore; last_dwen = ramWEN;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin cyc(1); k++; end
    chk(name, 32'(ack_q.size() >= n), 32'd1);
  endtask

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    cyc(2);
    RST = 0;
    chk("reset ramREN", 32'(ramREN), 32'd0);
    chk("reset ramWEN", 32'(ramWEN), 32'd0);
    chk("reset iwait", 32'(iwait), 32'd1);
    chk("reset dwait", 32'(dwait), 32'd1);
    chk("reset err", 32'(err), 32'd0);

    // Instruction fill alone
    ack_q.delete(); iaddr = 32'h40; iREN = 1;
    wait_acks(1, 10, "i_only timeout");
    iREN = 0; cyc(2);
    chk("i_only ack count", 32'(ack_q.size()), 32'd1);
    chk("i_only ack kind", 32'(ack_q[0]), 32'd1);
    chk("i_only iload", last_iload, 32'h8C010004);

    // Simultaneous requests: data first, then instruction
    ack_q.delete(); iaddr = 32'h80; daddr = 32'h200; iREN = 1; dREN = 1;
    wait_acks(1, 10, "simul d timeout");
    dREN = 0;
    wait_acks(2, 10, "simul i timeout");
    iREN = 0; cyc(2);
    chk("simul first", 32'(ack_q[0]), 32'd2);
    chk("simul second", 32'(ack_q[1]), 32'd1);

    // Starvation bound: four data acks, then one instruction ack
    ack_q.delete(); iaddr = 32'h44; daddr = 32'h300; iREN = 1; dREN = 1;
    wait_acks(5, 60, "starve timeout");
    for (int i = 0; i < 4; i++) chk("starve d ack", 32'(ack_q[i]), 32'd2);
    chk("starve i ack", 32'(ack_q[4]), 32'd1);
    wait_acks(6, 10, "starve reset timeout");
    dREN = 0; iREN = 0; cyc(2);
    chk("streak cleared, d wins", 32'(ack_q[5]), 32'd2);

    // Data write
    ack_q.delete(); daddr = 32'h100; dstore = 32'hDEADBEEF; dWEN = 1;
    wait_acks(1, 10, "write timeout");
    dWEN = 0; cyc(2);
    chk("write ack count", 32'(ack_q.size()), 32'd1);
    chk("write ramWEN", 32'(last_dwen), 32'd1);
    chk("write ramaddr", last_daddr, 32'h100);
    chk("write ramstore", last_dstore, 32'hDEADBEEF);

    // Request dropped mid-grant
    ack_q.delete(); lat = 20; daddr = 32'h120; dREN = 1;
    cyc(4);
    dREN = 0; cyc(3);
    chk("drop ack count", 32'(ack_q.size()), 32'd0);
    chk("drop ramREN", 32'(ramREN), 32'd0);

    // RAM error for three cycles then ACCESS
    ack_q.delete(); lat = 1; err_n = 3; daddr = 32'h140; dREN = 1;
    chk("err before", 32'(err), 32'd0);
    wait_acks(1, 20, "error timeout");
    dREN = 0; cyc(2);
    chk("error ack count", 32'(ack_q.size()), 32'd1);
    chk("error sticky", 32'(err), 32'd1);
    lat = 2; err_n = 0;

    // Reset during an instruction grant
    ack_q.delete(); lat = 20; iaddr = 32'h40; iREN = 1;
    cyc(3);
    chk("pre-reset ramREN", 32'(ramREN), 32'd1);
    RST = 1; cyc(1); RST = 0;
    chk("post-reset ramREN", 32'(ramREN), 32'd0);
    chk("post-reset iwait", 32'(iwait), 32'd1);
    chk("post-reset err", 32'(err), 32'd0);
    iREN = 0; cyc(3);
    chk("post-reset ack count", 32'(ack_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
